// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared types and constants for the RedMulE stream address generator
package redmule_pkg;

  localparam int ADDRGEN_DIMS = 4;
  localparam int ADDRGEN_AW   = 32;
  localparam int ADDRGEN_LW   = 16;

  typedef enum logic {
    IDLE,
    RUN
  } addrgen_state_e;

  typedef struct packed {
    logic [ADDRGEN_AW-1:0] base;
    logic [ADDRGEN_LW-1:0] tot_len;
    logic [ADDRGEN_LW-1:0] d0_len;
    logic [ADDRGEN_AW-1:0] d0_stride;
    logic [ADDRGEN_LW-1:0] d1_len;
    logic [ADDRGEN_AW-1:0] d1_stride;
    logic [ADDRGEN_LW-1:0] d2_len;
    logic [ADDRGEN_AW-1:0] d2_stride;
    logic [ADDRGEN_AW-1:0] d3_stride;
    logic [2:0]            dim_enable_1h;
  } addrgen_ctrl_t;

endpackage

// File: rtl/redmule_addrgen_dim_counter.sv
// rtl/redmule_addrgen_dim_counter.sv - one level of the strided pattern: wrapping index plus offset accumulator
module redmule_addrgen_dim_counter #(
  parameter int AW = 32,
  parameter int LW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          step_i,
  input  logic          wrap_en_i,
  input  logic [LW-1:0] len_i,
  input  logic [AW-1:0] stride_i,
  output logic [AW-1:0] off_o,
  output logic          wrap_o
);

  logic [LW-1:0] idx_q;
  logic [AW-1:0] off_q;

  // A zero length never wraps, so the level degenerates to a linear stride
  assign wrap_o = step_i && wrap_en_i && (len_i != '0) && (idx_q == len_i - LW'(1));
  assign off_o  = off_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      off_q <= '0;
    end else if (clear_i || wrap_o) begin
      idx_q <= '0;
      off_q <= '0;
    end else if (step_i) begin
      idx_q <= idx_q + LW'(1);
      off_q <= off_q + stride_i;
    end
  end

endmodule

// File: rtl/redmule_stream_addrgen.sv
// rtl/redmule_stream_addrgen.sv - strided TCDM address stream generator; REDMULE_ADDRGEN_PERF_EN adds stall_cnt_o
module redmule_stream_addrgen
  import redmule_pkg::*;
#(
  parameter int AW = ADDRGEN_AW,
  parameter int LW = ADDRGEN_LW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          req_start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [LW-1:0] tot_len_i,
  input  logic [LW-1:0] d0_len_i,
  input  logic [AW-1:0] d0_stride_i,
  input  logic [LW-1:0] d1_len_i,
  input  logic [AW-1:0] d1_stride_i,
  input  logic [LW-1:0] d2_len_i,
  input  logic [AW-1:0] d2_stride_i,
  input  logic [AW-1:0] d3_stride_i,
  input  logic [2:0]    dim_enable_1h_i,
  output logic          ready_start_o,
  output logic [AW-1:0] addr_o,
  output logic          addr_valid_o,
  input  logic          addr_ready_i,
`ifdef REDMULE_ADDRGEN_PERF_EN
  output logic [31:0]   stall_cnt_o,
`endif
  output logic          done_o
);

  addrgen_state_e state_q, state_d;
  addrgen_ctrl_t  ctrl_q;
  logic [LW-1:0]  cnt_q;
  logic           done_q;
  logic           start_run, start_empty, beat, last_beat, cnt_clr;

  logic [LW-1:0] lens    [ADDRGEN_DIMS-1];
  logic [AW-1:0] strides [ADDRGEN_DIMS];
  logic [AW-1:0] offs    [ADDRGEN_DIMS];
  logic          steps   [ADDRGEN_DIMS];
  logic          wraps   [ADDRGEN_DIMS-1];

  assign start_run   = (state_q == IDLE) && req_start_i && (tot_len_i != '0) && !clear_i;
  assign start_empty = (state_q == IDLE) && req_start_i && (tot_len_i == '0) && !clear_i;
  assign beat        = addr_valid_o && addr_ready_i;
  assign last_beat   = beat && (cnt_q == ctrl_q.tot_len - LW'(1));
  assign cnt_clr     = clear_i || start_run;

  assign ready_start_o = (state_q == IDLE);
  assign addr_valid_o  = (state_q == RUN);
  assign done_o        = done_q;
  assign addr_o        = ctrl_q.base + offs[0] + offs[1] + offs[2] + offs[3];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_start_i && (tot_len_i != '0)) state_d = RUN;
      RUN:     if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= start_empty || (last_beat && !clear_i);
      if (start_run) begin
        ctrl_q <= '{base: base_addr_i, tot_len: tot_len_i,
                    d0_len: d0_len_i, d0_stride: d0_stride_i,
                    d1_len: d1_len_i, d1_stride: d1_stride_i,
                    d2_len: d2_len_i, d2_stride: d2_stride_i,
                    d3_stride: d3_stride_i, dim_enable_1h: dim_enable_1h_i};
      end
      if (cnt_clr) cnt_q <= '0;
      else if (beat) cnt_q <= cnt_q + LW'(1);
    end
  end

  assign lens[0]    = ctrl_q.d0_len;
  assign lens[1]    = ctrl_q.d1_len;
  assign lens[2]    = ctrl_q.d2_len;
  assign strides[0] = ctrl_q.d0_stride;
  assign strides[1] = ctrl_q.d1_stride;
  assign strides[2] = ctrl_q.d2_stride;
  assign strides[3] = ctrl_q.d3_stride;

  // A wrap at level k replaces the level-k step with a step of level k+1
  assign steps[0] = beat;
  assign steps[1] = wraps[0];
  assign steps[2] = wraps[1];
  assign steps[3] = wraps[2];

  for (genvar k = 0; k < ADDRGEN_DIMS - 1; k++) begin : g_dim
    redmule_addrgen_dim_counter #(.AW(AW), .LW(LW)) i_dim (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (cnt_clr),
      .step_i    (steps[k]),
      .wrap_en_i (ctrl_q.dim_enable_1h[k]),
      .len_i     (lens[k]),
      .stride_i  (strides[k]),
      .off_o     (offs[k]),
      .wrap_o    (wraps[k])
    );
  end

  // Outermost level has no wrap control and is a plain accumulator
  logic [AW-1:0] off3_q;
  assign offs[3] = off3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          off3_q <= '0;
    else if (cnt_clr)     off3_q <= '0;
    else if (steps[3])    off3_q <= off3_q + strides[3];
  end

`ifdef REDMULE_ADDRGEN_PERF_EN
  logic [31:0] stall_q;
  assign stall_cnt_o = stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        stall_q <= '0;
    else if (cnt_clr)                   stall_q <= '0;
    else if (addr_valid_o && !addr_ready_i && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_redmule_stream_addrgen.sv
// tb/tb_redmule_stream_addrgen.sv - directed self-checking bench for redmule_stream_addrgen
module tb_redmule_stream_addrgen;

  logic        clk, rst_n, clear, req_start, ready_start, addr_valid, addr_ready, done;
  logic [31:0] base, d0_stride, d1_stride, d2_stride, d3_stride, addr;
  logic [15:0] tot_len, d0_len, d1_len, d2_len;
  logic [2:0]  dim;
`ifdef REDMULE_ADDRGEN_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  redmule_stream_addrgen dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .req_start_i     (req_start),
    .base_addr_i     (base),
    .tot_len_i       (tot_len),
    .d0_len_i        (d0_len),
    .d0_stride_i     (d0_stride),
    .d1_len_i        (d1_len),
    .d1_stride_i     (d1_stride),
    .d2_len_i        (d2_len),
    .d2_stride_i     (d2_stride),
    .d3_stride_i     (d3_stride),
    .dim_enable_1h_i (dim),
    .ready_start_o   (ready_start),
    .addr_o          (addr),
    .addr_valid_o    (addr_valid),
    .addr_ready_i    (addr_ready),
`ifdef REDMULE_ADDRGEN_PERF_EN
    .stall_cnt_o     (stall_cnt),
`endif
    .done_o          (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_req(input logic [31:0] b, input logic [15:0] tl, input logic [15:0] l0,
                         input logic [31:0] s0, input logic [15:0] l1, input logic [31:0] s1,
                         input logic [15:0] l2, input logic [31:0] s2, input logic [31:0] s3,
                         input logic [2:0] dm);
    req_start = 1'b1; base = b; tot_len = tl;
    d0_len = l0; d0_stride = s0; d1_len = l1; d1_stride = s1;
    d2_len = l2; d2_stride = s2; d3_stride = s3; dim = dm;
  endtask

  // Inputs scrambled after acceptance to prove they were latched
  task automatic scramble;
    req_start = 1'b0; base = 32'hdead_0000; tot_len = 16'd1;
    d0_stride = 32'h7; d1_stride = 32'h7; d2_stride = 32'h7; dim = 3'b111;
  endtask

  task automatic test_reset;
    tests++;
    if (ready_start !== 1'b1 || addr_valid !== 1'b0 || done !== 1'b0 || addr !== 32'h0) begin
      fails++;
      $display("FAIL reset: ready_start=%b valid=%b done=%b addr=%h, need 1 0 0 00000000",
               ready_start, addr_valid, done, addr);
    end
  endtask

  task automatic test_2d;
    logic [31:0] exp [4] = '{32'h1000, 32'h1080, 32'h1100, 32'h1180};
    set_req(32'h1000, 16'd4, 16'd1, 32'h0, 16'd4, 32'h80, 16'd0, 32'h0, 32'h0, 3'b011);
    addr_ready = 1'b1;
    @(negedge clk); scramble();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (addr_valid !== 1'b1 || addr !== exp[i] || done !== 1'b0) begin
        fails++;
        $display("FAIL 2d beat %0d: valid=%b addr=%h done=%b, need 1 %h 0", i, addr_valid, addr, done, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || addr_valid !== 1'b0 || ready_start !== 1'b1) begin
      fails++;
      $display("FAIL 2d done: done=%b valid=%b ready_start=%b, need 1 0 1", done, addr_valid, ready_start);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL 2d done width: done=%b, need 0", done);
    end
  endtask

  task automatic test_linear;
    logic [31:0] exp [3] = '{32'h2000, 32'h2040, 32'h2080};
    set_req(32'h2000, 16'd3, 16'd0, 32'h40, 16'd0, 32'h0, 16'd0, 32'h0, 32'h0, 3'b000);
    addr_ready = 1'b1;
    @(negedge clk); scramble();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (addr_valid !== 1'b1 || addr !== exp[i]) begin
        fails++;
        $display("FAIL linear beat %0d: valid=%b addr=%h, need 1 %h", i, addr_valid, addr, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL linear done: done=%b valid=%b, need 1 0", done, addr_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_cascade;
    logic [31:0] exp [6] = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h1000, 32'h1004};
    set_req(32'h0, 16'd6, 16'd2, 32'h4, 16'd2, 32'h100, 16'd0, 32'h1000, 32'h0, 3'b011);
    addr_ready = 1'b1;
    @(negedge clk); scramble();
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (addr_valid !== 1'b1 || addr !== exp[i]) begin
        fails++;
        $display("FAIL cascade beat %0d: valid=%b addr=%h, need 1 %h", i, addr_valid, addr, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL cascade done: done=%b valid=%b, need 1 0", done, addr_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] exp [4] = '{32'h1000, 32'h1080, 32'h1100, 32'h1180};
    set_req(32'h1000, 16'd4, 16'd1, 32'h0, 16'd4, 32'h80, 16'd0, 32'h0, 32'h0, 3'b011);
    addr_ready = 1'b1;
    @(negedge clk); scramble();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (addr_valid !== 1'b1 || addr !== exp[i]) begin
        fails++;
        $display("FAIL bp beat %0d: valid=%b addr=%h, need 1 %h", i, addr_valid, addr, exp[i]);
      end
      if (i < 2) @(negedge clk);
    end
    addr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (addr_valid !== 1'b1 || addr !== 32'h1100 || done !== 1'b0) begin
        fails++;
        $display("FAIL bp stall %0d: valid=%b addr=%h done=%b, need 1 00001100 0", k, addr_valid, addr, done);
      end
    end
    addr_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (addr_valid !== 1'b1 || addr !== 32'h1180) begin
      fails++;
      $display("FAIL bp resume: valid=%b addr=%h, need 1 00001180", addr_valid, addr);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp done: done=%b valid=%b, need 1 0", done, addr_valid);
    end
`ifdef REDMULE_ADDRGEN_PERF_EN
    tests++;
    if (stall_cnt !== 32'd3) begin
      fails++;
      $display("FAIL bp stall_cnt: got %0d, need 3", stall_cnt);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_abort;
    set_req(32'h1000, 16'd4, 16'd1, 32'h0, 16'd4, 32'h80, 16'd0, 32'h0, 32'h0, 3'b011);
    addr_ready = 1'b1;
    @(negedge clk); scramble();
    @(negedge clk);
    tests++;
    if (addr_valid !== 1'b1 || addr !== 32'h1080) begin
      fails++;
      $display("FAIL abort pre: valid=%b addr=%h, need 1 00001080", addr_valid, addr);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if (addr_valid !== 1'b0 || done !== 1'b0 || ready_start !== 1'b1) begin
      fails++;
      $display("FAIL abort post: valid=%b done=%b ready_start=%b, need 0 0 1", addr_valid, done, ready_start);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort late done: done=%b valid=%b, need 0 0", done, addr_valid);
    end
    set_req(32'h1000, 16'd4, 16'd1, 32'h0, 16'd4, 32'h80, 16'd0, 32'h0, 32'h0, 3'b011);
    @(negedge clk); scramble();
    tests++;
    if (addr_valid !== 1'b1 || addr !== 32'h1000) begin
      fails++;
      $display("FAIL abort restart: valid=%b addr=%h, need 1 00001000", addr_valid, addr);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_len_back_to_back;
    set_req(32'h3000, 16'd0, 16'd0, 32'h40, 16'd0, 32'h0, 16'd0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || addr_valid !== 1'b0 || ready_start !== 1'b1) begin
      fails++;
      $display("FAIL zero_len: done=%b valid=%b ready_start=%b, need 1 0 1", done, addr_valid, ready_start);
    end
    set_req(32'h2000, 16'd2, 16'd0, 32'h40, 16'd0, 32'h0, 16'd0, 32'h0, 32'h0, 3'b000);
    addr_ready = 1'b1;
    @(negedge clk); scramble();
    tests++;
    if (addr_valid !== 1'b1 || addr !== 32'h2000 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b after zero: valid=%b addr=%h done=%b, need 1 00002000 0", addr_valid, addr, done);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b first done: done=%b, need 1", done);
    end
    set_req(32'h5000, 16'd1, 16'd0, 32'h4, 16'd0, 32'h0, 16'd0, 32'h0, 32'h0, 3'b000);
    @(negedge clk); scramble();
    tests++;
    if (addr_valid !== 1'b1 || addr !== 32'h5000) begin
      fails++;
      $display("FAIL b2b second: valid=%b addr=%h, need 1 00005000", addr_valid, addr);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b second done: done=%b valid=%b, need 1 0", done, addr_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    set_req(32'h2000, 16'd3, 16'd0, 32'h40, 16'd0, 32'h0, 16'd0, 32'h0, 32'h0, 3'b000);
    addr_ready = 1'b1;
    @(negedge clk); scramble();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (addr_valid !== 1'b0 || ready_start !== 1'b1 || addr !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: valid=%b ready_start=%b addr=%h, need 0 1 00000000", addr_valid, ready_start, addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset after: done=%b valid=%b, need 0 0", done, addr_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; addr_ready = 1'b0;
    set_req(32'h0, 16'd0, 16'd0, 32'h0, 16'd0, 32'h0, 16'd0, 32'h0, 32'h0, 3'b000);
    req_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_2d();
    test_linear();
    test_cascade();
    test_backpressure();
    test_abort();
    test_zero_len_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
